// File: rtl/systolic_result_deskew.sv
// Deskews the systolic array's bottom-row wavefront, saturates each result to WIDTH
// and streams aligned rows out as single-word memory writes.
module systolic_result_deskew #(
  parameter int N          = 4,
  parameter int WIDTH      = 16,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [8:0]              n_rows,
  input  logic [N-1:0]            col_valid,
  input  logic [N*ACC_W-1:0]      col_data,
  input  logic [N-1:0]            col_ovf,
  output logic                    mem_write,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic signed [WIDTH-1:0] mem_data_write,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow_out,
  output logic                    misalign_err,
  output logic                    fifo_full_err,
  output logic [8:0]              rows_written
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int COL_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  function automatic logic signed [WIDTH-1:0] sat_word(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  function automatic logic sat_clip(input logic signed [ACC_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  state_t                  state_q, state_n;
  logic [N-1:0]            vld_al, ovf_al;
  logic [N*ACC_W-1:0]      dat_al;
  logic [N*WIDTH-1:0]      sat_row;
  logic                    clip_any;
  logic                    row_full, row_part, part_q;
  logic                    start_acc, accept_row, ev_full, ev_part, push, pop, drop;
  logic [8:0]              n_rows_q, rows_seen;
  logic [N*WIDTH-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        fifo_cnt;
  logic [N*WIDTH-1:0]      ser_buf;
  logic                    ser_act;
  logic [COL_W-1:0]        ser_col;
  logic [ADDR_W-1:0]       wr_addr;

  // Stage 0: per-column delay lines; column j waits N-1-j cycles so the wavefront lines up
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_pass
      assign vld_al[j]                   = col_valid[j];
      assign ovf_al[j]                   = col_ovf[j];
      assign dat_al[j*ACC_W +: ACC_W]    = col_data[j*ACC_W +: ACC_W];
    end else begin : g_dly
      logic [D-1:0]     vld_sr, ovf_sr;
      logic [ACC_W-1:0] dat_sr [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_sr <= '0;
          ovf_sr <= '0;
        end else begin
          vld_sr[0] <= col_valid[j];
          ovf_sr[0] <= col_ovf[j];
          for (int k = 1; k < D; k++) begin
            vld_sr[k] <= vld_sr[k-1];
            ovf_sr[k] <= ovf_sr[k-1];
          end
        end
      end
      always_ff @(posedge clk) begin
        dat_sr[0] <= col_data[j*ACC_W +: ACC_W];
        for (int k = 1; k < D; k++) dat_sr[k] <= dat_sr[k-1];
      end
      assign vld_al[j]                = vld_sr[D-1];
      assign ovf_al[j]                = ovf_sr[D-1];
      assign dat_al[j*ACC_W +: ACC_W] = dat_sr[D-1];
    end
  end

  // Stage 1: row assembly, saturation and push/pop decisions
  always_comb begin
    sat_row  = '0;
    clip_any = 1'b0;
    for (int j = 0; j < N; j++) begin
      sat_row[j*WIDTH +: WIDTH] = sat_word(dat_al[j*ACC_W +: ACC_W]);
      clip_any = clip_any | sat_clip(dat_al[j*ACC_W +: ACC_W]);
    end
  end

  assign row_full   = &vld_al;
  assign row_part   = (|vld_al) && !row_full;
  assign start_acc  = (state_q == S_IDLE) && start;
  assign accept_row = (state_q == S_ACTIVE) && (rows_seen < n_rows_q);
  assign ev_full    = accept_row && row_full;
  // A late column produces a run of partial cycles; the run counts as one row.
  assign ev_part    = accept_row && row_part && !part_q;
  assign pop        = (fifo_cnt != '0) && (!ser_act || ser_col == COL_LAST);
  assign push       = ev_full && ((fifo_cnt < DEPTH_C) || pop);
  assign drop       = ev_full && !push;

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:   if (start) state_n = S_ACTIVE;
      S_ACTIVE: if (rows_seen == n_rows_q && fifo_cnt == '0 && !ser_act) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      n_rows_q      <= '0;
      rows_seen     <= '0;
      part_q        <= 1'b0;
      overflow_out  <= 1'b0;
      misalign_err  <= 1'b0;
      fifo_full_err <= 1'b0;
    end else begin
      state_q <= state_n;
      part_q  <= row_part;
      if (start_acc) begin
        n_rows_q      <= n_rows;
        rows_seen     <= '0;
        busy          <= 1'b1;
        done          <= 1'b0;
        overflow_out  <= 1'b0;
        misalign_err  <= 1'b0;
        fifo_full_err <= 1'b0;
      end else begin
        if (ev_full || ev_part) rows_seen <= rows_seen + 9'd1;
        if (accept_row && row_part) misalign_err <= 1'b1;
        if (drop) fifo_full_err <= 1'b1;
        if (state_q == S_ACTIVE && ((|ovf_al) || (ev_full && clip_any))) overflow_out <= 1'b1;
        if (state_q == S_ACTIVE && state_n == S_DONE) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sat_row;
    if (pop)  ser_buf <= fifo_mem[rd_ptr];
  end

  // Stage 2: row FIFO bookkeeping and word serializer
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      ser_act        <= 1'b0;
      ser_col        <= '0;
      wr_addr        <= '0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_data_write <= '0;
      rows_written   <= '0;
    end else begin
      mem_write <= ser_act;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (ser_act) begin
        mem_addr       <= wr_addr;
        mem_data_write <= ser_buf[int'(ser_col)*WIDTH +: WIDTH];
        wr_addr        <= wr_addr + 1'b1;
        if (ser_col == COL_LAST) begin
          ser_col      <= '0;
          ser_act      <= 1'b0;
          rows_written <= rows_written + 9'd1;
        end else begin
          ser_col <= ser_col + 1'b1;
        end
      end
      if (pop) begin
        ser_act <= 1'b1;
        ser_col <= '0;
      end
      if (start_acc) begin
        wr_addr      <= base_addr;
        rows_written <= '0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_result_deskew.sv
// Scoreboard bench for systolic_result_deskew: a cycle-level row model predicts every
// memory write (address, data, cycle) and the end-of-capture status.
module tb_systolic_result_deskew;
  localparam int N = 4, WIDTH = 16, ACC_W = 32, FIFO_DEPTH = 4, ADDR_W = 12;
  localparam int MAXR = 16, MAXT = 128;

  logic                    clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [ADDR_W-1:0]       base_addr = '0;
  logic [8:0]              n_rows = '0;
  logic [N-1:0]            col_valid = '0, col_ovf = '0;
  logic [N*ACC_W-1:0]      col_data = '0;
  logic                    mem_write, busy, done, overflow_out, misalign_err, fifo_full_err;
  logic [ADDR_W-1:0]       mem_addr;
  logic signed [WIDTH-1:0] mem_data_write;
  logic [8:0]              rows_written;

  systolic_result_deskew #(.N(N), .WIDTH(WIDTH), .ACC_W(ACC_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .n_rows(n_rows),
    .col_valid(col_valid), .col_data(col_data), .col_ovf(col_ovf),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data_write(mem_data_write),
    .busy(busy), .done(done), .overflow_out(overflow_out), .misalign_err(misalign_err),
    .fifo_full_err(fifo_full_err), .rows_written(rows_written));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0]       addr;
    logic signed [WIDTH-1:0] data;
    int                      at;
  } wr_t;
  wr_t exp_q[$];

  int n_cmp = 0, n_bad = 0, n_wr = 0;
  int done_edge = -1;
  logic done_prev = 1'b0;

  // Monitor: every write must match the head of the expected queue, including its cycle
  always @(negedge clk) begin
    wr_t e;
    if (mem_write) begin
      n_wr++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write got addr=%h data=%0d cyc=%0d", mem_addr, mem_data_write, cyc);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_data_write !== e.data || cyc != e.at) begin
          n_bad++;
          $display("FAIL write got addr=%h data=%0d cyc=%0d required addr=%h data=%0d cyc=%0d",
                   mem_addr, mem_data_write, cyc, e.addr, e.data, e.at);
        end
      end
    end
    if (done && !done_prev) done_edge = cyc;
    done_prev = done;
  end

  // Row stimulus table and expectations
  int          r_start [MAXR];
  int          r_val   [MAXR][N];
  logic [N-1:0] r_ovf  [MAXR];
  int          r_late  [MAXR];
  int          nr;
  int          xs_t, xs_base, xs_n;
  logic [N-1:0] s_v [MAXT];
  logic [N-1:0] s_o [MAXT];
  int          s_d [MAXT][N];
  logic        exp_ovf, exp_mis, exp_ff;
  int          exp_rows, exp_done, exp_last_addr;

  task automatic chk(input string nm, input longint got, input longint req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s got=%0d required=%0d", nm, got, req);
    end
  endtask

  task automatic clear_rows();
    nr = 0;
    xs_t = -1;
  endtask

  task automatic add_row(input int st, input int v0, input int v1, input int v2, input int v3,
                         input logic [N-1:0] om, input int late);
    r_start[nr] = st;
    r_val[nr][0] = v0; r_val[nr][1] = v1; r_val[nr][2] = v2; r_val[nr][3] = v3;
    r_ovf[nr] = om;
    r_late[nr] = late;
    nr++;
  endtask

  // Reference model: row k's last column is sampled at edge es+start+N; FIFO rows leave at
  // max(push+1, previous pop+N); a row is dropped when FIFO_DEPTH accepted rows are still queued.
  task automatic run_model(input int es, input int base, input int nrows);
    int seen, acc, last_pop, last_ev, last_wr, ev, occ, p, sv;
    int pops[$];
    seen = 0; acc = 0; last_pop = -1000; last_ev = 0; last_wr = 0;
    exp_ovf = 0; exp_mis = 0; exp_ff = 0; exp_last_addr = 0;
    for (int k = 0; k < nr; k++) begin
      ev = es + r_start[k] + N;
      if (seen >= nrows) continue;
      seen++;
      last_ev = ev;
      if (r_ovf[k] != '0) exp_ovf = 1;
      if (r_late[k] >= 0) begin
        exp_mis = 1;
        continue;
      end
      for (int c = 0; c < N; c++)
        if (r_val[k][c] > 32767 || r_val[k][c] < -32768) exp_ovf = 1;
      occ = 0;
      foreach (pops[i]) if (pops[i] > ev) occ++;
      if (occ >= FIFO_DEPTH) begin
        exp_ff = 1;
        continue;
      end
      p = (ev + 1 > last_pop + N) ? ev + 1 : last_pop + N;
      last_pop = p;
      pops.push_back(p);
      for (int c = 0; c < N; c++) begin
        sv = (r_val[k][c] > 32767) ? 32767 : (r_val[k][c] < -32768) ? -32768 : r_val[k][c];
        exp_q.push_back('{addr: ADDR_W'(base + acc*N + c), data: WIDTH'(sv), at: p + 1 + c});
        exp_last_addr = (base + acc*N + c) % (1 << ADDR_W);
      end
      last_wr = p + N;
      acc++;
    end
    exp_rows = acc;
    exp_done = es + 1;
    if (last_ev + 1 > exp_done) exp_done = last_ev + 1;
    if (last_wr + 1 > exp_done) exp_done = last_wr + 1;
  endtask

  task automatic do_start(input int base, input int nrw, output int es);
    start = 1'b1; base_addr = ADDR_W'(base); n_rows = 9'(nrw);
    @(negedge clk);
    start = 1'b0;
    es = cyc;
    #1;
    chk("busy_after_start", {busy, done}, 2'b10);
  endtask

  task automatic play();
    int len, t;
    len = 0;
    for (int i = 0; i < MAXT; i++) begin
      s_v[i] = '0; s_o[i] = '0;
      for (int c = 0; c < N; c++) s_d[i][c] = 0;
    end
    for (int k = 0; k < nr; k++)
      for (int c = 0; c < N; c++) begin
        t = r_start[k] + c + ((c == r_late[k]) ? 1 : 0);
        s_v[t][c] = 1'b1;
        s_o[t][c] = r_ovf[k][c];
        s_d[t][c] = r_val[k][c];
        if (t + 1 > len) len = t + 1;
      end
    if (xs_t >= len) len = xs_t + 1;
    for (int i = 0; i < len; i++) begin
      col_valid = s_v[i];
      col_ovf   = s_o[i];
      for (int c = 0; c < N; c++) col_data[c*ACC_W +: ACC_W] = s_d[i][c];
      start     = (i == xs_t);
      base_addr = (i == xs_t) ? ADDR_W'(xs_base) : ADDR_W'($urandom);
      n_rows    = (i == xs_t) ? 9'(xs_n) : 9'($urandom);
      @(negedge clk);
    end
    col_valid = '0; col_ovf = '0; col_data = '0; start = 1'b0;
  endtask

  task automatic finish_capture(input string nm);
    int k;
    k = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({nm, "_done_seen"}, done, 1);
    chk({nm, "_done_cycle"}, done_edge, exp_done);
    repeat (3) @(negedge clk);
    #1;
    chk({nm, "_flags"}, {overflow_out, misalign_err, fifo_full_err}, {exp_ovf, exp_mis, exp_ff});
    chk({nm, "_rows_written"}, rows_written, exp_rows);
    chk({nm, "_busy_done"}, {busy, done}, 2'b01);
    chk({nm, "_pending_writes"}, exp_q.size(), 0);
    if (exp_rows > 0) chk({nm, "_addr_hold"}, mem_addr, exp_last_addr);
  endtask

  task automatic check_all_zero(input string nm);
    chk(nm, {mem_write, mem_addr, mem_data_write, busy, done, overflow_out, misalign_err,
             fifo_full_err, rows_written}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int es, w0, k, nrw, st, base;
    int v[N];
    logic [N-1:0] om;

    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("idle_outputs");

    // Basic capture: rows back-to-back, value r*10+c
    clear_rows();
    for (int r = 0; r < 4; r++) add_row(r, r*10, r*10+1, r*10+2, r*10+3, 4'b0, -1);
    do_start(12'h100, 4, es);
    run_model(es, 12'h100, 4);
    play();
    finish_capture("basic");

    // Saturation of both polarities
    clear_rows();
    add_row(0, 40000, -40000, 5, -5, 4'b0, -1);
    do_start(12'h000, 1, es);
    run_model(es, 12'h000, 1);
    play();
    finish_capture("saturate");

    // In-range row with a PE overflow flag on column 2
    clear_rows();
    add_row(0, 1, 2, 3, 4, 4'b0100, -1);
    do_start(12'h010, 1, es);
    run_model(es, 12'h010, 1);
    play();
    finish_capture("col_ovf");

    // Misaligned row 0 (column 2 late), good row 1
    clear_rows();
    add_row(0, 7, 8, 9, 10, 4'b0, 2);
    add_row(6, 11, 12, 13, 14, 4'b0, -1);
    do_start(12'h020, 2, es);
    run_model(es, 12'h020, 2);
    play();
    finish_capture("misalign");

    // FIFO overflow: seven rows back-to-back
    clear_rows();
    for (int r = 0; r < 7; r++) add_row(r, r*100, r*100+1, -r, r*100+3, 4'b0, -1);
    do_start(12'h400, 7, es);
    run_model(es, 12'h400, 7);
    play();
    finish_capture("fifo_full");

    // Reset in the middle of writing
    clear_rows();
    for (int r = 0; r < 4; r++) add_row(r, r+50, r+60, r+70, r+80, 4'b0, -1);
    w0 = n_wr;
    do_start(12'h300, 4, es);
    run_model(es, 12'h300, 4);
    play();
    k = 0;
    while (n_wr < w0 + 5 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("midop_writes_before_reset", n_wr - w0, 5);
    rst = 1'b1;
    @(negedge clk);
    #1;
    exp_q.delete();
    check_all_zero("midop_reset_outputs");
    rst = 1'b0;
    clear_rows();
    add_row(0, 1000, 2000, 3000, 4000, 4'b0, -1);
    do_start(12'h200, 1, es);
    run_model(es, 12'h200, 1);
    play();
    finish_capture("after_reset");

    // n_rows = 0
    clear_rows();
    do_start(12'h055, 0, es);
    run_model(es, 12'h055, 0);
    play();
    finish_capture("zero_rows");

    // Start pulse while busy must not relatch base_addr/n_rows
    clear_rows();
    add_row(0, 21, 22, 23, 24, 4'b0, -1);
    add_row(3, 31, 32, 33, 34, 4'b0, -1);
    xs_t = 2; xs_base = 12'h7F0; xs_n = 5;
    do_start(12'h040, 2, es);
    run_model(es, 12'h040, 2);
    play();
    finish_capture("start_busy");

    // Address wrap
    clear_rows();
    add_row(0, -1, -2, -3, -4, 4'b0, -1);
    do_start(12'hFFE, 1, es);
    run_model(es, 12'hFFE, 1);
    play();
    finish_capture("wrap");

    // Randomized captures
    for (int it = 0; it < 8; it++) begin
      clear_rows();
      nrw  = $urandom_range(1, 6);
      base = $urandom_range(0, 4095);
      st   = 0;
      for (int r = 0; r < nrw + $urandom_range(0, 1); r++) begin
        for (int c = 0; c < N; c++)
          v[c] = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 60000)) - 30000;
        om = (r < nrw && $urandom_range(0, 7) == 0) ? N'(1 << $urandom_range(0, N-1)) : '0;
        add_row(st, v[0], v[1], v[2], v[3], om, -1);
        st += $urandom_range(1, 5);
      end
      do_start(base, nrw, es);
      run_model(es, base, nrw);
      play();
      finish_capture("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
